// File: rtl/hazard_scoreboard_pkg.sv
// Purpose : shared types and constants for the D-stage hazard scoreboard.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: sb_entry_t (one tracked in-flight register write), REG_ZERO, FWD_RF,
//           default stage count / field width / mult-div latencies, saturating Tnew decrement.
package hazard_pkg;

    // Tnew is stored in a fixed-width field wide enough for any reasonable TW;
    // the top zero-extends its TW-wide inputs into it.
    localparam int TNEW_W = 8;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         FWD_RF   = 0;

    localparam int DEF_NSTAGE   = 3;
    localparam int DEF_TW       = 2;
    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;

    typedef struct packed {
        logic              vld;
        logic [4:0]        waddr;
        logic [TNEW_W-1:0] tnew;
    } sb_entry_t;

    // Tnew counts down one per stage and sticks at zero once the value exists.
    function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? t : t - TNEW_W'(1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// Purpose : loadable down-counter flagging the mult/div unit as busy.
// Latency : load takes effect next cycle; busy is registered-state only.
// Backpressure: none; the caller gates load with its own stall.
// Ports   : clk, rst_n (async active-low), load/load_val (start new op), busy (count nonzero).
module md_busy_counter
    import hazard_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Purpose : D-stage hazard unit: scoreboard of in-flight writes -> stall and D-stage forward selects.
// Latency : outputs combinational from scoreboard state and D inputs; a D writer appears as entry[0] next cycle.
// Backpressure: stall freezes PC/IF-ID and turns the E-stage slot into a bubble.
// Ports   : clk, rst_n (async active-low); d_* describe the D-stage instruction;
//           stall, fwd_rs_sel/fwd_rt_sel (0 = regfile, k = k stages after D), md_busy.
// Config  : define HAZARD_MD_EN to include the mult/div busy counter; otherwise md_busy = 0
//           and the d_md_* inputs are ignored.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int NSTAGE   = DEF_NSTAGE,
    parameter  int TW       = DEF_TW,
    parameter  int MULT_LAT = DEF_MULT_LAT,
    parameter  int DIV_LAT  = DEF_DIV_LAT,
    localparam int SEL_W    = $clog2(NSTAGE + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_valid,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic             d_rs_use,
    input  logic             d_rt_use,
    input  logic [TW-1:0]    d_tuse_rs,
    input  logic [TW-1:0]    d_tuse_rt,
    input  logic             d_we,
    input  logic [4:0]       d_waddr,
    input  logic [TW-1:0]    d_tnew,
    input  logic             d_md_start,
    input  logic             d_md_div,
    input  logic             d_md_use,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_rs_sel,
    output logic [SEL_W-1:0] fwd_rt_sel,
    output logic             md_busy
);

    sb_entry_t entry_q [NSTAGE];
    sb_entry_t entry_d [NSTAGE];

    logic [NSTAGE-1:0] hit_rs;
    logic [NSTAGE-1:0] hit_rt;
    logic [NSTAGE-1:0] late_rs;
    logic [NSTAGE-1:0] late_rt;
    // Priority chains: index NSTAGE is the "no match" tail, lower index wins.
    logic [SEL_W-1:0]  rs_chain [NSTAGE+1];
    logic [SEL_W-1:0]  rt_chain [NSTAGE+1];
    logic              stall_md;

    // Shift: D enters as entry[0] unless stalled/empty/non-writing; oldest entry falls off the end.
    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            entry_d[k] = '0;
        end
        if (!stall && d_valid && d_we) begin
            entry_d[0].vld   = 1'b1;
            entry_d[0].waddr = d_waddr;
            entry_d[0].tnew  = TNEW_W'(d_tnew);
        end
        for (int k = 1; k < NSTAGE; k++) begin
            entry_d[k]      = entry_q[k-1];
            entry_d[k].tnew = tnew_dec(entry_q[k-1].tnew);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTAGE; k++) begin
                entry_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                entry_q[k] <= entry_d[k];
            end
        end
    end

    assign rs_chain[NSTAGE] = SEL_W'(FWD_RF);
    assign rt_chain[NSTAGE] = SEL_W'(FWD_RF);

    for (genvar k = 0; k < NSTAGE; k++) begin : g_cmp
        assign hit_rs[k]  = entry_q[k].vld && (entry_q[k].waddr == d_rs)
                            && (d_rs != REG_ZERO) && d_rs_use;
        assign hit_rt[k]  = entry_q[k].vld && (entry_q[k].waddr == d_rt)
                            && (d_rt != REG_ZERO) && d_rt_use;
        assign late_rs[k] = hit_rs[k] && (entry_q[k].tnew > TNEW_W'(d_tuse_rs));
        assign late_rt[k] = hit_rt[k] && (entry_q[k].tnew > TNEW_W'(d_tuse_rt));
        // The youngest match decides alone: if its value is not ready yet the
        // select stays on the regfile even if an older writer has a value.
        assign rs_chain[k] = !hit_rs[k]               ? rs_chain[k+1]    :
                             (entry_q[k].tnew == '0)  ? SEL_W'(k + 1)    :
                                                        SEL_W'(FWD_RF);
        assign rt_chain[k] = !hit_rt[k]               ? rt_chain[k+1]    :
                             (entry_q[k].tnew == '0)  ? SEL_W'(k + 1)    :
                                                        SEL_W'(FWD_RF);
    end

    assign fwd_rs_sel = rs_chain[0];
    assign fwd_rt_sel = rt_chain[0];
    assign stall      = (|late_rs) || (|late_rt) || stall_md;

`ifdef HAZARD_MD_EN
    localparam int MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    logic            md_load;
    logic [MD_W-1:0] md_load_val;

    // A start held back by a register stall must not load; it retries when released.
    assign md_load     = d_md_start && d_valid && !stall;
    assign md_load_val = d_md_div ? MD_W'(DIV_LAT) : MD_W'(MULT_LAT);

    md_busy_counter #(
        .CNT_W (MD_W)
    ) u_md_busy_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (md_load),
        .load_val (md_load_val),
        .busy     (md_busy)
    );

    assign stall_md = md_busy && d_md_use && d_valid;
`else
    localparam int unused_lat = MULT_LAT + DIV_LAT;
    logic unused_md;
    assign unused_md = ^{d_md_start, d_md_div, d_md_use};
    assign md_busy   = 1'b0;
    assign stall_md  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Purpose : directed self-checking bench for hazard_scoreboard (default parameters).
// Latency : inputs driven at the falling edge, outputs sampled 1 ns later; state commits on the rising edge.
// Backpressure: stall expectations are hand-derived per cycle from the scoreboard contents.
module tb_hazard_scoreboard;

`ifdef HAZARD_MD_EN
    localparam bit MD_ON = 1'b1;
`else
    localparam bit MD_ON = 1'b0;
`endif
    localparam int DIV_LAT = 10;

    logic       clk;
    logic       rst_n;
    logic       d_valid;
    logic [4:0] d_rs, d_rt;
    logic       d_rs_use, d_rt_use;
    logic [1:0] d_tuse_rs, d_tuse_rt;
    logic       d_we;
    logic [4:0] d_waddr;
    logic [1:0] d_tnew;
    logic       d_md_start, d_md_div, d_md_use;
    logic       stall;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
    logic       md_busy;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_valid    (d_valid),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_rs_use   (d_rs_use),
        .d_rt_use   (d_rt_use),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_we       (d_we),
        .d_waddr    (d_waddr),
        .d_tnew     (d_tnew),
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .d_md_use   (d_md_use),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .md_busy    (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Valid D slot with no sources, no write, no md activity.
    task automatic idle();
        d_valid    = 1'b1;
        d_rs       = 5'd0;
        d_rt       = 5'd0;
        d_rs_use   = 1'b0;
        d_rt_use   = 1'b0;
        d_tuse_rs  = 2'd0;
        d_tuse_rt  = 2'd0;
        d_we       = 1'b0;
        d_waddr    = 5'd0;
        d_tnew     = 2'd0;
        d_md_start = 1'b0;
        d_md_div   = 1'b0;
        d_md_use   = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        d_valid = 1'b0;
        #1;
        check("rst_stall", stall, 0);
        check("rst_fwd_rs", fwd_rs_sel, 0);
        check("rst_fwd_rt", fwd_rt_sel, 0);
        check("rst_md_busy", md_busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // lw $8 (tnew 2)
        cyc(); d_we = 1; d_waddr = 5'd8; d_tnew = 2'd2; #1;
        check("lw_issue_stall", stall, 0);
        // addu $9,$8,$8 (tuse 1): entry0 {8, tnew 2} -> stall
        cyc(); d_rs = 8; d_rs_use = 1; d_tuse_rs = 1; d_rt = 8; d_rt_use = 1; d_tuse_rt = 1;
        d_we = 1; d_waddr = 5'd9; d_tnew = 2'd1; #1;
        check("lw_use_stall", stall, 1);
        // Retry: lw now in M with tnew 1 == tuse -> release; not ready, so regfile select
        cyc(); d_rs = 8; d_rs_use = 1; d_tuse_rs = 1; d_rt = 8; d_rt_use = 1; d_tuse_rt = 1;
        d_we = 1; d_waddr = 5'd9; d_tnew = 2'd1; #1;
        check("lw_release_stall", stall, 0);
        check("lw_release_fwd_rs", fwd_rs_sel, 0);
        check("lw_release_fwd_rt", fwd_rt_sel, 0);
        // lw now in W with tnew 0: reader of $8 forwards from stage 3
        cyc(); d_rs = 8; d_rs_use = 1; d_rt_use = 1; #1;
        check("lw_w_fwd_rs", fwd_rs_sel, 3);
        check("lw_w_fwd_rt_zero", fwd_rt_sel, 0);
        check("lw_w_stall", stall, 0);

        // ori $3,$9 (tnew 1); addu $9 sits in M with tnew 0 -> forward from 2
        cyc(); d_rs = 9; d_rs_use = 1; d_tuse_rs = 1; d_we = 1; d_waddr = 5'd3; d_tnew = 2'd1; #1;
        check("ori_fwd_rs_m", fwd_rs_sel, 2);
        check("ori_stall", stall, 0);
        // beq $3,$0 (tuse 0): entry0 {3, tnew 1} -> stall
        cyc(); d_rs = 3; d_rs_use = 1; d_rt_use = 1; #1;
        check("beq_stall", stall, 1);
        check("beq_stall_fwd_rt", fwd_rt_sel, 0);
        cyc(); d_rs = 3; d_rs_use = 1; d_rt_use = 1; #1;
        check("beq_release_stall", stall, 0);
        check("beq_fwd_rs", fwd_rs_sel, 2);
        check("beq_fwd_rt", fwd_rt_sel, 0);

        // addu $5 twice, then sw $5 (rt tuse 2)
        cyc(); d_we = 1; d_waddr = 5'd5; d_tnew = 2'd1; #1;
        check("addu5a_stall", stall, 0);
        cyc(); d_rs = 5; d_rs_use = 1; d_tuse_rs = 1; d_we = 1; d_waddr = 5'd5; d_tnew = 2'd1; #1;
        check("addu5b_stall", stall, 0);
        check("addu5b_fwd_rs", fwd_rs_sel, 0);
        // entry0 {5,1}, entry1 {5,0}: youngest not ready, older ready match ignored
        cyc(); d_rs = 29; d_rs_use = 1; d_tuse_rs = 1; d_rt = 5; d_rt_use = 1; d_tuse_rt = 2; #1;
        check("sw_stall", stall, 0);
        check("sw_fwd_rt_youngest", fwd_rt_sel, 0);
        check("sw_fwd_rs_none", fwd_rs_sel, 0);
        // entry1 {5,0}, entry2 {5,0}: youngest (stage 2) wins over stage 3
        cyc(); d_rt = 5; d_rt_use = 1; #1;
        check("dup_fwd_rt_youngest", fwd_rt_sel, 2);
        check("dup_stall", stall, 0);

        // Writer to $0 with tnew 2, then a reader of $0
        cyc(); d_we = 1; d_waddr = 5'd0; d_tnew = 2'd2; #1;
        check("w0_issue_stall", stall, 0);
        cyc(); d_rs_use = 1; d_rt_use = 1; #1;
        check("r0_stall", stall, 0);
        check("r0_fwd_rs", fwd_rs_sel, 0);
        check("r0_fwd_rt", fwd_rt_sel, 0);

        // div, then mflo held off while the divider is busy
        cyc(); d_md_start = 1; d_md_div = 1; d_md_use = 1; #1;
        check("div_issue_stall", stall, 0);
        check("div_issue_busy", md_busy, 0);
        for (int i = 0; i < DIV_LAT; i++) begin
            cyc(); d_md_use = 1; d_we = 1; d_waddr = 5'd10; d_tnew = 2'd1; #1;
            check("mflo_stall", stall, MD_ON);
            check("mflo_busy", md_busy, MD_ON);
        end
        cyc(); d_md_use = 1; d_we = 1; d_waddr = 5'd10; d_tnew = 2'd1; #1;
        check("mflo_release_stall", stall, 0);
        check("mflo_release_busy", md_busy, 0);

        // Reset in the middle of a lw stall (with a mult in flight when configured)
        cyc(); d_md_start = 1; d_md_use = 1; #1;
        check("mult_issue_stall", stall, 0);
        cyc(); d_we = 1; d_waddr = 5'd8; d_tnew = 2'd2; #1;
        check("lw2_issue_busy", md_busy, MD_ON);
        cyc(); d_rs = 8; d_rs_use = 1; d_tuse_rs = 1; #1;
        check("lw2_use_stall", stall, 1);
        check("lw2_use_busy", md_busy, MD_ON);
        #1; rst_n = 1'b0; #1;
        check("midrst_stall", stall, 0);
        check("midrst_fwd_rs", fwd_rs_sel, 0);
        check("midrst_md_busy", md_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(); d_rs = 8; d_rs_use = 1; d_tuse_rs = 0; d_rt = 9; d_rt_use = 1; #1;
        check("postrst_stall", stall, 0);
        check("postrst_fwd_rs", fwd_rs_sel, 0);
        check("postrst_fwd_rt", fwd_rt_sel, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
